cntpop_pipe: RTL and testbench
==============================

Name: cntpop_pipe

Overview:
- Parametrised, pipelined population-count unit; successor to the fixed-width byte-LUT popcount blocks.
- Counts set bits across a WID-bit operand with a two-stage elastic pipeline.
- Three modes: whole-word count, per-byte SIMD counts, and a running accumulated count.
- Sits in the integer ALU / bit-manipulation path; valid/ready on both sides.

Parameters:
- WID, 64, operand width in bits; multiple of 8, range 8..128.
- ACCW, 32, accumulator width in bits; must be >= $clog2(WID+1).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- ld_i  in  1  input valid.
- rdy_o  out  1  input ready; transfer when ld_i & rdy_o.
- mode_i  in  2  00 whole count, 01 per-byte, 10 accumulate, 11 reserved (treated as 00).
- clr_i  in  1  synchronous clear of accumulator.
- i  in  WID  operand.
- vld_o  out  1  output valid.
- rdy_i  in  1  downstream ready; output consumed when vld_o & rdy_i.
- o  out  WID/2  result. Whole mode: zero-extended count. Per-byte mode: 4-bit count of byte k in o[4k+3:4k]. Accumulate mode: zero-extended low bits of acc after update.
- acc_o  out  ACCW  current accumulator value.
- sat_o  out  1  sticky accumulator-saturated flag.

Behaviour:
- Reset (rst_ni low, async): s1_vld=0, s2_vld=0, vld_o=0, o=0, acc_o=0, sat_o=0. rdy_o=1 once reset deasserts.
- Stage 1 (S1): registers WID/8 byte counts (4 bits each) and mode. Loads on ld_i & rdy_o.
- Stage 2 (S2): registers the final result and drives o/vld_o.
  - Whole mode: sum of all byte counts.
  - Per-byte mode: packed byte counts.
  - Accumulate mode: acc + sum.
- Latency: 2 cycles from accepted input to vld_o with no stall.
- Throughput: 1 result per cycle.
- Advance rules:
  - s2_adv = s1_vld & (~s2_vld | rdy_i).
  - rdy_o = ~s1_vld | s2_adv.
  - S2 holds o and vld_o stable while vld_o & ~rdy_i.
- Accumulator:
  - Updates only when an accumulate-mode op moves S1->S2.
  - Saturates at 2^ACCW-1 and sets sat_o.
  - clr_i sets acc=0 and sat_o=0.
  - clr_i in the same cycle as an accumulate update: clear applies first, then acc = sum of the advancing op.
  - Whole and per-byte ops never touch acc.
- Boundaries:
  - i=0 gives 0.
  - i=all ones gives WID (whole) and 8 per byte (per-byte).
  - Back-to-back accumulate ops chain correctly through S2 without a bubble.
  - Reset mid-operation discards all in-flight ops.
  - ld_i while ~rdy_o is ignored; the operand must be held by the source.

Optional Feature:
- Macro CNTPOP_PIPE_MASK_EN.
- Defined:
  - Adds input port msk_i [WID-1:0].
  - S1 counts (i & msk_i), sampled with i.
  - Per-byte and accumulate modes also use the masked operand.
- Undefined:
  - No msk_i port; the full operand is counted.

Test Plan:
- WID=64, mode 00, i=64'hFFFF_FFFF_FFFF_FFFF, rdy_i=1 -> vld_o high exactly 2 cycles after accept, o=64.
- WID=64, mode 01, i=64'h0103_070F_1F3F_7FFF -> o=32'h1234_5678 (byte7..byte0 counts 1..8 left to right).
- Streaming 4 ops (i=1,3,7,F) with rdy_i low for 3 cycles after the first result:
  - rdy_o drops once both stages are full.
  - o holds 1 during the stall.
  - Results 1,2,3,4 arrive in order with no loss or duplication.
- Accumulate:
  - clr_i, then mode 10 ops i=FF,FF,0F -> acc_o=8,16,20, sat_o=0.
  - Then ACCW=4 build, two ops of FF -> acc_o=15, sat_o=1.
  - clr_i -> acc_o=0, sat_o=0.
- Assert rst_ni low with both stages valid -> vld_o=0, acc_o=0 immediately (async); after release, first new op returns a correct count.
- CNTPOP_PIPE_MASK_EN defined, i=all ones, msk_i=64'h0000_0000_0000_00F0, mode 00 -> o=4.

Source files
------------

// File: rtl/cntpop_pipe.sv
// Two-stage elastic population-count unit: whole-word, per-byte and accumulating modes.
// Optional CNTPOP_PIPE_MASK_EN adds msk_i; the operand counted is then i & msk_i.
module cntpop_pipe #(
    parameter int WID  = 64,
    parameter int ACCW = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ld_i,
    output logic              rdy_o,
    input  logic [1:0]        mode_i,
    input  logic              clr_i,
    input  logic [WID-1:0]    i,
`ifdef CNTPOP_PIPE_MASK_EN
    input  logic [WID-1:0]    msk_i,
`endif
    output logic              vld_o,
    input  logic              rdy_i,
    output logic [WID/2-1:0]  o,
    output logic [ACCW-1:0]   acc_o,
    output logic              sat_o
);

    localparam int NB = WID / 8;
    localparam int SW = $clog2(WID + 1);
    localparam int OW = WID / 2;

    localparam logic [1:0] MODE_WHOLE = 2'b00;
    localparam logic [1:0] MODE_BYTE  = 2'b01;
    localparam logic [1:0] MODE_ACC   = 2'b10;

    function automatic logic [3:0] popcnt8(input logic [7:0] x);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 0; k < 8; k++) c = c + {3'b000, x[k]};
        return c;
    endfunction

    logic [WID-1:0]       opnd;
    logic [NB-1:0][3:0]   bc_d;
    logic                 s1_vld;
    logic [NB-1:0][3:0]   s1_cnt;
    logic [1:0]           s1_mode;
    logic                 s2_adv;
    logic [SW-1:0]        sum;
    logic [ACCW-1:0]      acc_base;
    logic                 sat_base;
    logic [ACCW:0]        acc_sum;
    logic [ACCW-1:0]      acc_new;
    logic                 sat_new;
    logic [OW-1:0]        res;

`ifdef CNTPOP_PIPE_MASK_EN
    assign opnd = i & msk_i;
`else
    assign opnd = i;
`endif

    always_comb begin
        bc_d = '0;
        for (int b = 0; b < NB; b++) bc_d[b] = popcnt8(opnd[8*b +: 8]);
    end

    assign s2_adv = s1_vld & (~vld_o | rdy_i);
    assign rdy_o  = ~s1_vld | s2_adv;

    // Clear is folded in ahead of the add so a same-cycle clr_i restarts from this op's sum.
    always_comb begin
        sum = '0;
        for (int b = 0; b < NB; b++) sum = sum + SW'(s1_cnt[b]);
        acc_base = clr_i ? '0 : acc_o;
        sat_base = clr_i ? 1'b0 : sat_o;
        acc_sum  = {1'b0, acc_base} + {{(ACCW + 1 - SW){1'b0}}, sum};
        acc_new  = acc_sum[ACCW] ? '1 : acc_sum[ACCW-1:0];
        sat_new  = sat_base | acc_sum[ACCW];
        case (s1_mode)
            MODE_BYTE: res = s1_cnt;
            MODE_ACC:  res = OW'(acc_new);
            default:   res = OW'(sum);
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld  <= 1'b0;
            s1_cnt  <= '0;
            s1_mode <= MODE_WHOLE;
        end else if (ld_i && rdy_o) begin
            s1_vld  <= 1'b1;
            s1_cnt  <= bc_d;
            s1_mode <= (mode_i == 2'b11) ? MODE_WHOLE : mode_i;
        end else if (s2_adv) begin
            s1_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_o <= 1'b0;
            o     <= '0;
        end else if (s2_adv) begin
            vld_o <= 1'b1;
            o     <= res;
        end else if (rdy_i) begin
            vld_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_o <= '0;
            sat_o <= 1'b0;
        end else if (s2_adv && (s1_mode == MODE_ACC)) begin
            acc_o <= acc_new;
            sat_o <= sat_new;
        end else if (clr_i) begin
            acc_o <= '0;
            sat_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cntpop_pipe.sv
// Directed bench for cntpop_pipe: a WID=64 instance plus a WID=8/ACCW=4 instance for saturation.
module tb_cntpop_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        ld = 1'b0, rdy_o, clr = 1'b0, vld, rdy_i = 1'b1, sat;
    logic [1:0]  mode = 2'b00;
    logic [63:0] din = '0;
    logic [63:0] msk = '1;
    logic [31:0] o;
    logic [31:0] acc;

    logic        ld1 = 1'b0, rdy_o1, clr1 = 1'b0, vld1, sat1;
    logic [1:0]  mode1 = 2'b00;
    logic [7:0]  din1 = '0;
    logic [7:0]  msk1 = '1;
    logic [3:0]  o1;
    logic [3:0]  acc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cntpop_pipe #(.WID(64), .ACCW(32)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .ld_i(ld), .rdy_o(rdy_o), .mode_i(mode),
        .clr_i(clr), .i(din),
`ifdef CNTPOP_PIPE_MASK_EN
        .msk_i(msk),
`endif
        .vld_o(vld), .rdy_i(rdy_i), .o(o), .acc_o(acc), .sat_o(sat)
    );

    cntpop_pipe #(.WID(8), .ACCW(4)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .ld_i(ld1), .rdy_o(rdy_o1), .mode_i(mode1),
        .clr_i(clr1), .i(din1),
`ifdef CNTPOP_PIPE_MASK_EN
        .msk_i(msk1),
`endif
        .vld_o(vld1), .rdy_i(1'b1), .o(o1), .acc_o(acc1), .sat_o(sat1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic [3:0] ops [4] = '{4'h1, 4'h3, 4'h7, 4'hF};
    logic [31:0] exps [4] = '{32'd1, 32'd2, 32'd3, 32'd4};

    initial begin
        int nin, nout, stall_left;
        bit first_seen, saw_block;

        // Reset state
        #2;
        check("rst_vld", vld, 0);
        check("rst_o", o, 0);
        check("rst_acc", acc, 0);
        check("rst_sat", sat, 0);
        step();
        rst_n = 1'b1;
        #1;
        check("rst_rdy", rdy_o, 1);

        // Whole-word all ones, latency
        step();
        ld = 1'b1; mode = 2'b00; din = '1;
        step();
        ld = 1'b0;
        check("lat_early_vld", vld, 0);
        step();
        check("lat_vld", vld, 1);
        check("whole_ones", o, 64);
        step();
        check("lat_drop_vld", vld, 0);

        // Per-byte counts
        ld = 1'b1; mode = 2'b01; din = 64'h0103_070F_1F3F_7FFF;
        step();
        ld = 1'b0;
        step();
        check("byte_vld", vld, 1);
        check("byte_counts", o, 32'h1234_5678);

        // Zero operand then reserved mode with all ones, back to back
        ld = 1'b1; mode = 2'b00; din = '0;
        step();
        mode = 2'b11; din = '1;
        step();
        ld = 1'b0;
        check("whole_zero", o, 0);
        step();
        check("mode11_whole", o, 64);
        step();

        // Streaming with a 3-cycle downstream stall after the first result
        nin = 0; nout = 0; stall_left = 0; first_seen = 0; saw_block = 0;
        mode = 2'b00;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) step();
            if (vld && !first_seen) begin
                first_seen = 1;
                stall_left = 3;
            end
            rdy_i = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            ld  = (nin < 4);
            din = (nin < 4) ? {60'd0, ops[nin]} : '0;
            #1;
            if (!rdy_i) begin
                check("stall_vld", vld, 1);
                check("stall_hold_o", o, 1);
                check("stall_rdy_low", rdy_o, 0);
                saw_block = 1;
            end
            if (vld && rdy_i) begin
                if (nout < 4) check("stream_order", o, exps[nout]);
                nout++;
            end
            if (ld && rdy_o) nin++;
        end
        ld = 1'b0;
        rdy_i = 1'b1;
        check("stream_blocked", saw_block, 1);
        check("stream_in_cnt", nin, 4);
        check("stream_out_cnt", nout, 4);
        check("stream_idle_vld", vld, 0);

        // Accumulate chain
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("acc_clr", acc, 0);
        ld = 1'b1; mode = 2'b10; din = 64'hFF;
        step();
        din = 64'hFF;
        step();
        din = 64'h0F;
        check("acc_8", acc, 8);
        check("acc_o_8", o, 8);
        step();
        ld = 1'b0;
        check("acc_16", acc, 16);
        step();
        check("acc_20", acc, 20);
        check("acc_o_20", o, 20);
        check("acc_sat0", sat, 0);

        // Whole op leaves acc untouched
        ld = 1'b1; mode = 2'b00; din = 64'hFF;
        step();
        ld = 1'b0;
        step();
        check("whole_no_acc_o", o, 8);
        check("whole_no_acc", acc, 20);

        // Clear in the same cycle as an accumulate update
        ld = 1'b1; mode = 2'b10; din = 64'hFFFF;
        step();
        ld = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_upd_acc", acc, 16);
        check("clr_upd_o", o, 16);

        // Saturation on the narrow instance
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        ld1 = 1'b1; mode1 = 2'b10; din1 = 8'hFF;
        step();
        step();
        ld1 = 1'b0;
        check("n_acc_8", acc1, 8);
        check("n_sat0", sat1, 0);
        step();
        check("n_acc_sat", acc1, 15);
        check("n_sat1", sat1, 1);
        check("n_o_sat", o1, 15);
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        check("n_clr_acc", acc1, 0);
        check("n_clr_sat", sat1, 0);

        // Async reset with both stages full
        rdy_i = 1'b0;
        ld = 1'b1; mode = 2'b00; din = 64'hFF;
        step();
        din = 64'hF;
        step();
        ld = 1'b0;
        #1;
        check("full_vld", vld, 1);
        check("full_rdy", rdy_o, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_vld", vld, 0);
        check("arst_acc", acc, 0);
        check("arst_o", o, 0);
        step();
        rst_n = 1'b1;
        rdy_i = 1'b1;
        ld = 1'b1; mode = 2'b00; din = 64'hF0F0;
        step();
        ld = 1'b0;
        check("post_rst_nostale", vld, 0);
        step();
        check("post_rst_vld", vld, 1);
        check("post_rst_o", o, 8);

`ifdef CNTPOP_PIPE_MASK_EN
        step();
        msk = 64'h0000_0000_0000_00F0;
        ld = 1'b1; mode = 2'b00; din = '1;
        step();
        ld = 1'b0;
        step();
        check("mask_whole", o, 4);
        msk = '1;
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
